id_issue_stage: RTL and testbench

//  Decode/issue pipeline stage sitting directly upstream of regfile: takes pre-decoded instructions from IF,

---
 rtl/id_issue_stage_pkg.sv | 16 +
 rtl/id_issue_stage_if.sv | 39 +++
 rtl/id_issue_stage_reg_scoreboard.sv | 49 ++++
 rtl/id_issue_stage.sv | 93 +++++++++
 tb/tb_id_issue_stage.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/id_issue_stage_pkg.sv
// Shared definitions for the decode/issue stage: register file geometry and
// pipeline-slot field widths.
package id_issue_stage_pkg;
  localparam int REG_NUM = 32;
  localparam int REG_AW  = 5;
  localparam int XLEN    = 32;
  localparam int INST_W  = 32;

  typedef logic [REG_AW-1:0] reg_idx_t;

  localparam reg_idx_t R0 = 5'd0;

  function automatic logic is_r0(input reg_idx_t idx);
    return idx == R0;
  endfunction
endpackage

// File: rtl/id_issue_stage_if.sv
// IF->ID instruction channel and ID->EX pipeline-slot channel of the issue stage.
interface id_issue_stage_if import id_issue_stage_pkg::*; #(
  parameter int PC_W = 32
);
  // Handshake: a transfer happens on the rising edge where valid and ready are
  // both high; ready never depends on valid, and an un-accepted payload is
  // simply re-presented by the producer on a later cycle.
  logic              id_valid;
  logic              id_ready;
  logic [PC_W-1:0]   id_pc;
  logic [INST_W-1:0] id_inst;
  reg_idx_t          id_rj;
  logic              id_src1_en;
  reg_idx_t          id_rk;
  logic              id_src2_en;
  reg_idx_t          id_rd;
  logic              id_rd_we;

  logic              ex_valid;
  logic              ex_ready;
  logic [PC_W-1:0]   ex_pc;
  logic [INST_W-1:0] ex_inst;
  logic [XLEN-1:0]   ex_src1;
  logic [XLEN-1:0]   ex_src2;
  reg_idx_t          ex_rd;
  logic              ex_rd_we;

  modport master (
    output id_valid, id_pc, id_inst, id_rj, id_src1_en, id_rk, id_src2_en,
           id_rd, id_rd_we, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_inst, ex_src1, ex_src2, ex_rd, ex_rd_we
  );

  modport slave (
    input  id_valid, id_pc, id_inst, id_rj, id_src1_en, id_rk, id_src2_en,
           id_rd, id_rd_we, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_inst, ex_src1, ex_src2, ex_rd, ex_rd_we
  );
endinterface

// File: rtl/id_issue_stage_reg_scoreboard.sv
// Per-register in-flight writer counters. r0 is never counted; a simultaneous
// increment and decrement of the same register leaves it unchanged.
module reg_scoreboard import id_issue_stage_pkg::*; #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_en,
  input  reg_idx_t         inc_addr,
  input  logic             dec_en,
  input  reg_idx_t         dec_addr,
  input  logic             clr,
  input  reg_idx_t         q_addr1,
  input  reg_idx_t         q_addr2,
  input  reg_idx_t         q_addr3,
  output logic [CNT_W-1:0] q_cnt1,
  output logic [CNT_W-1:0] q_cnt2,
  output logic [CNT_W-1:0] q_cnt3
);
  logic [CNT_W-1:0]   cnt [REG_NUM];
  logic [REG_NUM-1:0] up;
  logic [REG_NUM-1:0] dn;

  // Saturation is prevented upstream; a decrement at zero is dropped here.
  always_comb begin
    up = '0;
    dn = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      up[i] = inc_en && (inc_addr == REG_AW'(i));
      dn[i] = dec_en && (dec_addr == REG_AW'(i)) && (cnt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < REG_NUM; i++) begin
      if (reset || clr || i == 0) begin
        cnt[i] <= '0;
      end else if (up[i] && !dn[i]) begin
        cnt[i] <= cnt[i] + 1'b1;
      end else if (dn[i] && !up[i]) begin
        cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  assign q_cnt1 = cnt[q_addr1];
  assign q_cnt2 = cnt[q_addr2];
  assign q_cnt3 = cnt[q_addr3];
endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: drives regfile read addresses, stalls RAW hazards and
// writer saturation via the scoreboard, and registers operands into the EX slot.
module id_issue_stage import id_issue_stage_pkg::*; #(
  parameter int CNT_W = 2,
  parameter int PC_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  id_issue_stage_if.slave   io,
  output reg_idx_t          rf_raddr1,
  output reg_idx_t          rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              wb_we,
  input  reg_idx_t          wb_waddr,
  input  logic              flush
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]  cnt1, cnt2, cnt3;
  logic              hazard1, hazard2, sat, ready, fire;

  logic              valid_q;
  logic [PC_W-1:0]   pc_q;
  logic [INST_W-1:0] inst_q;
  logic [XLEN-1:0]   src1_q, src2_q;
  reg_idx_t          rd_q;
  logic              rd_we_q;

  assign rf_raddr1 = io.id_rj;
  assign rf_raddr2 = io.id_rk;

  // The last outstanding write landing this cycle is bypassed by the regfile.
  assign hazard1 = io.id_src1_en && !is_r0(io.id_rj) && (cnt1 != '0) &&
                   !(wb_we && (wb_waddr == io.id_rj) && (cnt1 == CNT_ONE));
  assign hazard2 = io.id_src2_en && !is_r0(io.id_rk) && (cnt2 != '0) &&
                   !(wb_we && (wb_waddr == io.id_rk) && (cnt2 == CNT_ONE));
  assign sat     = io.id_rd_we && !is_r0(io.id_rd) && (cnt3 == CNT_MAX) &&
                   !(wb_we && (wb_waddr == io.id_rd));

  assign ready = !flush && !hazard1 && !hazard2 && !sat && (!valid_q || io.ex_ready);
  assign fire  = io.id_valid && ready;

  reg_scoreboard #(.CNT_W(CNT_W)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .inc_en   (fire && io.id_rd_we && !is_r0(io.id_rd)),
    .inc_addr (io.id_rd),
    .dec_en   (wb_we && !flush),
    .dec_addr (wb_waddr),
    .clr      (flush),
    .q_addr1  (io.id_rj),
    .q_addr2  (io.id_rk),
    .q_addr3  (io.id_rd),
    .q_cnt1   (cnt1),
    .q_cnt2   (cnt2),
    .q_cnt3   (cnt3)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      rd_q    <= '0;
      rd_we_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (fire) begin
      valid_q <= 1'b1;
      pc_q    <= io.id_pc;
      inst_q  <= io.id_inst;
      src1_q  <= io.id_src1_en ? rf_rdata1 : '0;
      src2_q  <= io.id_src2_en ? rf_rdata2 : '0;
      rd_q    <= io.id_rd;
      rd_we_q <= io.id_rd_we;
    end else if (io.ex_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign io.id_ready = ready;
  assign io.ex_valid = valid_q;
  assign io.ex_pc    = pc_q;
  assign io.ex_inst  = inst_q;
  assign io.ex_src1  = src1_q;
  assign io.ex_src2  = src2_q;
  assign io.ex_rd    = rd_q;
  assign io.ex_rd_we = rd_we_q;
endmodule

// File: tb/tb_id_issue_stage.sv
// Randomized and directed bench for id_issue_stage against a cycle-level
// reference model of the scoreboard counts and the EX slot.
module tb_id_issue_stage;
  import id_issue_stage_pkg::*;

  localparam int PC_W = 32;
  localparam int CMAX = 3;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            wb_we;
  reg_idx_t        wb_waddr;
  reg_idx_t        rf_raddr1, rf_raddr2;
  logic [XLEN-1:0] rf_rdata1, rf_rdata2;

  id_issue_stage_if #(.PC_W(PC_W)) io ();

  id_issue_stage #(.CNT_W(2), .PC_W(PC_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .io        (io),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .flush     (flush)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int          m_cnt [REG_NUM];
  bit          m_valid;
  logic [31:0] m_pc, m_inst, m_src1, m_src2;
  logic [4:0]  m_rd;
  bit          m_rd_we;
  bit          exp_rdy;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_hazard(input bit en, input int idx);
    if (!en || idx == 0 || m_cnt[idx] == 0) return 1'b0;
    if (wb_we && int'(wb_waddr) == idx && m_cnt[idx] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_ready();
    bit sat;
    sat = io.id_rd_we && io.id_rd != 0 && m_cnt[io.id_rd] == CMAX &&
          !(wb_we && wb_waddr == io.id_rd);
    return !flush && !model_hazard(io.id_src1_en, int'(io.id_rj)) &&
           !model_hazard(io.id_src2_en, int'(io.id_rk)) && !sat &&
           (!m_valid || io.ex_ready);
  endfunction

  task automatic model_clock();
    int dec_r;
    bit fire;
    if (reset) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_valid = 0; m_pc = 0; m_inst = 0; m_src1 = 0; m_src2 = 0; m_rd = 0; m_rd_we = 0;
    end else if (flush) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_valid = 0;
    end else begin
      fire  = io.id_valid && exp_rdy;
      dec_r = -1;
      if (wb_we && wb_waddr != 0 && m_cnt[wb_waddr] > 0) dec_r = int'(wb_waddr);
      if (fire) begin
        m_valid = 1;
        m_pc    = io.id_pc;
        m_inst  = io.id_inst;
        m_src1  = io.id_src1_en ? rf_rdata1 : 32'd0;
        m_src2  = io.id_src2_en ? rf_rdata2 : 32'd0;
        m_rd    = io.id_rd;
        m_rd_we = io.id_rd_we;
        if (io.id_rd_we && io.id_rd != 0) m_cnt[io.id_rd]++;
      end else if (io.ex_ready) begin
        m_valid = 0;
      end
      if (dec_r >= 0) m_cnt[dec_r]--;
    end
  endtask

  // Driver tasks
  task automatic set_idle();
    io.id_valid = 0; io.id_pc = '0; io.id_inst = '0;
    io.id_rj = '0; io.id_src1_en = 0; io.id_rk = '0; io.id_src2_en = 0;
    io.id_rd = '0; io.id_rd_we = 0;
    rf_rdata1 = '0; rf_rdata2 = '0;
  endtask

  task automatic drive_inst(input bit v, input logic [4:0] rj, input bit s1,
                            input logic [4:0] rk, input bit s2,
                            input logic [4:0] rd, input bit we);
    io.id_valid = v; io.id_pc = $urandom; io.id_inst = $urandom;
    io.id_rj = rj; io.id_src1_en = s1; io.id_rk = rk; io.id_src2_en = s2;
    io.id_rd = rd; io.id_rd_we = we;
    rf_rdata1 = (rj == 0) ? 32'd0 : $urandom;
    rf_rdata2 = (rk == 0) ? 32'd0 : $urandom;
  endtask

  // One cycle: inputs already driven in the low phase, checked around the edge.
  task automatic tick();
    #1;
    exp_rdy = model_ready();
    check_eq("id_ready", io.id_ready, exp_rdy);
    check_eq("rf_raddr1", rf_raddr1, io.id_rj);
    check_eq("rf_raddr2", rf_raddr2, io.id_rk);
    @(posedge clk);
    model_clock();
    #1;
    check_eq("ex_valid", io.ex_valid, m_valid);
    check_eq("ex_pc", io.ex_pc, m_pc);
    check_eq("ex_inst", io.ex_inst, m_inst);
    check_eq("ex_src1", io.ex_src1, m_src1);
    check_eq("ex_src2", io.ex_src2, m_src2);
    check_eq("ex_rd", io.ex_rd, m_rd);
    check_eq("ex_rd_we", io.ex_rd_we, m_rd_we);
    for (int i = 0; i < 10; i++) check_eq("cnt", dut.u_sb.cnt[i], m_cnt[i]);
    @(negedge clk);
  endtask

  initial begin
    reset = 1; flush = 0; wb_we = 0; wb_waddr = '0; io.ex_ready = 1;
    set_idle();
    drive_inst(1, 5'd1, 1, 5'd2, 1, 5'd3, 1);
    @(posedge clk);
    @(negedge clk);
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_valid = 0; m_pc = 0; m_inst = 0; m_src1 = 0; m_src2 = 0; m_rd = 0; m_rd_we = 0;

    // Reset held with a valid instruction offered
    repeat (3) tick();
    reset = 0;

    // Back-to-back independent writers
    for (int r = 1; r <= 3; r++) begin
      drive_inst(1, 5'd0, 0, 5'd0, 0, 5'(r), 1);
      tick();
    end
    set_idle(); tick();

    // RAW stall resolved by writeback of the only outstanding write
    drive_inst(1, 5'd0, 0, 5'd0, 0, 5'd5, 1); tick();
    drive_inst(1, 5'd5, 1, 5'd1, 0, 5'd6, 1); tick(); tick();
    wb_we = 1; wb_waddr = 5'd5; tick();
    wb_we = 0; set_idle(); tick();

    // Saturation of r7
    repeat (3) begin
      drive_inst(1, 5'd0, 0, 5'd0, 0, 5'd7, 1); tick();
    end
    drive_inst(1, 5'd0, 0, 5'd0, 0, 5'd7, 1); tick(); tick();
    wb_we = 1; wb_waddr = 5'd7; tick();
    wb_we = 0; set_idle(); tick();

    // r0 as source and destination
    drive_inst(1, 5'd0, 1, 5'd0, 1, 5'd0, 1); tick(); tick();

    // EX backpressure then flush
    drive_inst(1, 5'd0, 0, 5'd0, 0, 5'd9, 1); tick();
    io.ex_ready = 0;
    drive_inst(1, 5'd0, 0, 5'd0, 0, 5'd8, 1);
    repeat (4) tick();
    flush = 1; tick();
    flush = 0; io.ex_ready = 1; set_idle(); tick();

    // Randomized traffic over a small register window to provoke hazards
    for (int n = 0; n < 1500; n++) begin
      drive_inst($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      io.ex_ready = $urandom_range(0, 9) < 7;
      wb_we       = 1'($urandom_range(0, 1));
      wb_waddr    = 5'($urandom_range(0, 7));
      flush       = $urandom_range(0, 49) == 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
